spi_frame_buffer: RTL

//  Parametrised single-clock frame buffer between the SPI receiver and the servo command decoder.

---
 rtl/spi_buf_pkg.sv | 19 +
 rtl/spi_frame_ram.sv | 28 ++
 rtl/spi_frame_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spi_buf_pkg.sv
// Shared types and defaults for the SPI frame buffer.
package spi_buf_pkg;

   // Buffer mode: collecting a frame, or replaying it downstream.
   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } buf_state_t;

   localparam int DEF_EOF_CODE  = 256;
   localparam int DEF_IDLE_CODE = 0;
   localparam int STAT_W        = 16;

   // RAM address width; a single-entry RAM still needs one address bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/spi_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module spi_frame_ram #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 256,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read; rd_data holds its value while rd_en is low.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/spi_frame_buffer.sv
// Single-frame buffer between the SPI receiver and the servo command decoder.
// Collects words until EOF_CODE, then replays the frame on a valid/ready stream.
// Optional statistics counters enabled by defining SPI_FRAME_BUF_STATS_EN.
module spi_frame_buffer
   import spi_buf_pkg::*;
#(
   parameter int DATA_W    = 9,
   parameter int DEPTH     = 256,
   parameter int EOF_CODE  = DEF_EOF_CODE,
   parameter int IDLE_CODE = DEF_IDLE_CODE
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_last,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] frame_len,
   output logic                       busy,
   output logic                       overflow,
   output logic [STAT_W-1:0]          frame_cnt,
   output logic [STAT_W-1:0]          drop_cnt
);

   localparam int LEN_W = $clog2(DEPTH+1);
   localparam int AW    = addr_w(DEPTH);
   localparam logic [DATA_W-1:0] EOF_W   = DATA_W'(EOF_CODE);
   localparam logic [DATA_W-1:0] IDLE_W  = DATA_W'(IDLE_CODE);
   localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

   buf_state_t        state;
   logic [LEN_W-1:0]  rd_ptr;
   logic              rd_vld;   // RAM read register holds an unconsumed word
   logic              rd_last;  // that word is the frame's final one
   logic [DATA_W-1:0] rd_q;

   logic accept, is_idle, is_eof, wr_en, drop, start_drain;
   logic load_out, rd_en, end_frame;

   assign in_ready = (state == FILL);
   assign busy     = (state == DRAIN);

   // Handshake decode. The write pointer is the stored word count, so
   // frame_len doubles as the RAM write address.
   always_comb begin
      accept      = in_valid & (state == FILL);
      is_idle     = (in_data == IDLE_W);
      is_eof      = (in_data == EOF_W);
      wr_en       = accept & ~is_idle & ~is_eof & (frame_len < DEPTH_L);
      drop        = accept & ~is_idle & ~is_eof & (frame_len == DEPTH_L);
      start_drain = accept & is_eof & (frame_len != '0);
      // Output register takes the RAM word when empty or being consumed.
      load_out    = rd_vld & (~out_valid | out_ready);
      // Issue the next read only when the RAM register is free or emptying,
      // which keeps one word per cycle with out_ready held high.
      rd_en       = (state == DRAIN) & (rd_ptr < frame_len) & (~rd_vld | load_out);
      end_frame   = (state == DRAIN) & out_valid & out_ready & out_last;
   end

   spi_frame_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (AW'(frame_len)),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (AW'(rd_ptr)),
      .rd_data (rd_q)
   );

   // Mode FSM with pointers, output register and overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         frame_len <= '0;
         rd_ptr    <= '0;
         rd_vld    <= 1'b0;
         rd_last   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (wr_en)       frame_len <= frame_len + LEN_W'(1);
               if (drop)        overflow  <= 1'b1;
               if (start_drain) state     <= DRAIN;
            end
            DRAIN: begin
               if (rd_en) begin
                  rd_ptr  <= rd_ptr + LEN_W'(1);
                  rd_last <= (rd_ptr == frame_len - LEN_W'(1));
               end
               rd_vld <= rd_en | (rd_vld & ~load_out);
               if (load_out) begin
                  out_valid <= 1'b1;
                  out_data  <= rd_q;
                  out_last  <= rd_last;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
               if (end_frame) begin
                  state     <= FILL;
                  frame_len <= '0;
                  rd_ptr    <= '0;
                  rd_vld    <= 1'b0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifdef SPI_FRAME_BUF_STATS_EN
   // Wrapping frame and dropped-word counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (end_frame) frame_cnt <= frame_cnt + STAT_W'(1);
         if (drop)      drop_cnt  <= drop_cnt + STAT_W'(1);
      end
   end
`else
   assign frame_cnt = '0;
   assign drop_cnt  = '0;
`endif

endmodule
